// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered ps2_clk, 11-bit frame
// deserialiser with timeout, and a scan-code FIFO with sticky error flags.
module ps2_keyboard_rx_fifo #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  input  logic              clr_flags,
  output logic [7:0]        data,
  output logic              ready,
  output logic [ADDR_W:0]   fill,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk;
  logic                   sdata;

  logic [FW-1:0]          filt_cnt;
  logic                   filt;
  logic                   filt_d;
  logic                   sample;

  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic [TW-1:0]          tcnt;
  logic                   timeout;

  logic                   frame_done;
  logic                   bad_frame;
  logic                   bad_par;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   accept;
  logic [ADDR_W:0]        fill_next;

  logic [7:0]             mem [DEPTH];
  logic [ADDR_W-1:0]      w_ptr;
  logic [ADDR_W-1:0]      r_ptr;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (sclk != filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt     <= sclk;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign sample = filt_d & ~filt;

  // After ten shifts: shift[0]=start, shift[8:1]=data, shift[9]=parity.
  assign frame_done = sample && (bit_cnt == 4'd10);
  assign bad_frame  = frame_done && (shift[0] || !sdata);
  assign bad_par    = frame_done && !bad_frame && !(^shift[9:1]);
  assign push       = frame_done && !bad_frame && !bad_par;
  assign timeout    = (bit_cnt != 4'd0) && !sample && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_cnt <= '0;
      shift   <= '0;
      tcnt    <= '0;
    end else if (sample) begin
      tcnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
      end else begin
        shift   <= {sdata, shift[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt == 4'd0) begin
      tcnt <= '0;
    end else if (timeout) begin
      bit_cnt <= '0;
      tcnt    <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign pop    = ready && !nextdata_n;
  assign full   = (fill == (ADDR_W+1)'(DEPTH));
  assign accept = push && (!full || pop);

  always_comb begin
    fill_next = fill;
    case ({accept, pop})
      2'b10:   fill_next = fill + 1'b1;
      2'b01:   fill_next = fill - 1'b1;
      default: fill_next = fill;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      fill  <= '0;
      ready <= 1'b0;
    end else begin
      if (accept) w_ptr <= w_ptr + 1'b1;
      if (pop)    r_ptr <= r_ptr + 1'b1;
      fill  <= fill_next;
      ready <= (fill_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[w_ptr] <= shift[8:1];
  end

  assign data = mem[r_ptr];

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= (push && !accept) || (overflow   && !clr_flags);
      parity_err <= bad_par           || (parity_err && !clr_flags);
      frame_err  <= bad_frame || timeout || (frame_err && !clr_flags);
    end
  end

endmodule

// File: doc/ps2_keyboard_rx_fifo.md
Name: ps2_keyboard_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver. It deserialises 11-bit PS/2 device-to-host frames into 8-bit scan codes and buffers them in a FIFO whose depth is set by parameter. Compared with the basic receiver it adds a ps2_clk glitch filter, a mid-frame timeout, a drop-on-full policy, sticky error flags and a FIFO fill level. It sits between the PS/2 pins and the scan-code decoder/display logic.

Parameters:
ADDR_W, 3, FIFO depth is 2**ADDR_W entries (minimum 1).
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data before filtering (minimum 2).
FILTER_LEN, 4, number of consecutive equal synced ps2_clk samples needed to change the filtered level (minimum 1).
TIMEOUT_CYCLES, 5000, clk cycles without a filtered falling edge before a partial frame is abandoned (minimum 2).

Ports:
clk  in  1  system clock
clr  in  1  asynchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
nextdata_n  in  1  active-low pop request, sampled on clk
clr_flags  in  1  one-cycle pulse that clears the sticky flags
data  out  8  scan code at the read pointer, combinational from the FIFO
ready  out  1  FIFO non-empty
fill  out  ADDR_W+1  number of entries held, 0..2**ADDR_W
overflow  out  1  sticky: a frame was dropped because the FIFO was full
parity_err  out  1  sticky: a frame failed the odd-parity check
frame_err  out  1  sticky: bad start bit, bad stop bit, or timeout

Behaviour:
- Reset (async assert, sync release): bit counter=0, pointers=0, fill=0, ready=0, overflow=0, parity_err=0, frame_err=0. The filtered clock level and all sync stages reset to 1. Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- Filter: the filtered clock level changes only after FILTER_LEN consecutive synced samples differ from the current level.
- Sample pulse: asserted for one cycle on a 1->0 transition of the filtered level. ps2_data is taken from the data synchroniser in that same cycle.
- Frame: bit 0 start (must be 0), bits 1-8 data LSB first, bit 9 odd parity, bit 10 stop (must be 1).
- Sample pulses 1-10 shift bits into a 10-bit buffer and increment the counter.
- Sample pulse 11 evaluates the frame and resets the counter to 0.
- Evaluation priority:
  - Start=1 or stop=0: set frame_err, no push.
  - Otherwise, XOR of bits 1-9 = 0: set parity_err, no push.
  - Otherwise: push.
- Push: writes the byte to fifo[w_ptr] and increments w_ptr (wraps modulo 2**ADDR_W). It is accepted when fill < 2**ADDR_W, or when a pop occurs in the same cycle. Otherwise the byte is discarded, overflow is set, and w_ptr is unchanged.
- Pop: occurs when ready=1 and nextdata_n=0 at a clk edge. r_ptr increments (wraps). Holding nextdata_n low pops once per cycle. A pop request while empty is ignored.
- fill update rules:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - ready = (fill != 0), registered consistently with fill.
- Latency: the byte is visible on data with ready=1 on the clk edge after the 11th sample pulse (first entry case). data is unspecified while ready=0.
- Timeout: a cycle counter runs while the bit counter != 0 and resets on each sample pulse. When it reaches TIMEOUT_CYCLES, the bit counter returns to 0 and frame_err is set. The counter is idle when the bit counter = 0.
- Sticky flags: clr_flags clears them. If a set event and clr_flags coincide, the set wins.
- Push/pop logic is independent of the frame receive path, so a pop is never blocked by reception.

Test Plan:
- Reset, then send frame 0x1C (start 0, data 0x1C, parity 0, stop 1) -> data=0x1C, ready=1, fill=1, all flags 0; pulse nextdata_n -> ready=0, fill=0.
- ADDR_W=3: send 0x01..0x09 without popping -> fill=8, overflow=1. Eight pops return 0x01..0x08; 0x09 is never seen.
- Fill to 8, then hold nextdata_n low in the exact cycle a 9th frame 0x55 completes -> push accepted, fill stays 8, overflow=0; the last pop returns 0x55.
- Send 0x1C with parity bit 1 -> parity_err=1, fill unchanged. Send a frame with stop bit 0 -> frame_err=1. Pulse clr_flags -> both 0.
- TIMEOUT_CYCLES=100: send 5 bits, idle 150 cycles, then full frame 0x2A -> frame_err=1, data=0x2A, fill=1.
- Inject 2-cycle low glitches on ps2_clk (FILTER_LEN=4) during a 0x33 frame -> received 0x33, no flags. Separately, assert clr after bit 6 of a frame, then send 0x44 -> fill=1, data=0x44.
